// File: rtl/audio_out_fifo_if.sv
// Signal bundle between the NeXT sound-out decoder side, the I2S sender side
// and the audio output FIFO. The FIFO connects through the slave modport.
interface audio_out_fifo_if #(
    parameter int DEPTH_LOG2 = 2,
    parameter int UCNT_W     = 16
);
    // Handshake rule: every *_valid, *_tick, cmd_* and *_out pulse is a
    // single-cycle strobe sampled on the rising clock edge; there is no ready
    // back-pressure, so a strobe that cannot be honoured is dropped and
    // accounted for (overflow / underrun) instead of being stalled.
    logic                  cmd_start;
    logic                  cmd_end;
    logic                  cmd_22k;
    logic                  sample_valid;
    logic [31:0]           sample_data;
    logic                  req_mode;
    logic                  req_tick;
    logic                  status_clr;

    logic                  out_valid;
    logic [31:0]           out_data;
    logic                  audio_start_out;
    logic                  audio_end_out;
    logic                  audio_22k_out;
    logic                  host_req;
    logic [DEPTH_LOG2:0]   fifo_level;
    logic [UCNT_W-1:0]     underrun_count;
    logic                  overflow;
    logic [1:0]            dbg_state;

    modport master (
        output cmd_start, cmd_end, cmd_22k, sample_valid, sample_data,
               req_mode, req_tick, status_clr,
        input  out_valid, out_data, audio_start_out, audio_end_out,
               audio_22k_out, host_req, fifo_level, underrun_count,
               overflow, dbg_state
    );

    modport slave (
        input  cmd_start, cmd_end, cmd_22k, sample_valid, sample_data,
               req_mode, req_tick, status_clr,
        output out_valid, out_data, audio_start_out, audio_end_out,
               audio_22k_out, host_req, fifo_level, underrun_count,
               overflow, dbg_state
    );
endinterface

// File: rtl/audio_out_fifo.sv
// Stereo sample buffer between the NeXT sound-out link and the I2S sender:
// pops one sample per sender tick, prefetches from the host, sequences start/drain/stop.
module audio_out_fifo #(
    parameter int DEPTH_LOG2 = 2,
    parameter int UCNT_W     = 16
) (
    input  logic             in_clk,
    input  logic             rst_n,
    audio_out_fifo_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;

    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;
    localparam logic [LW-1:0]         LVL_ONE  = 1;
    localparam logic [LW-1:0]         LVL_FULL = LW'(DEPTH);
    localparam logic [LW:0]           SUM_CAP  = (LW + 1)'(DEPTH);
    localparam logic [UCNT_W-1:0]     UCNT_ONE = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [31:0]           mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic [LW-1:0]         outst_q, outst_d;
    logic [UCNT_W-1:0]     ucnt_q, ucnt_d;
    logic                  ovf_q, ovf_d;
    logic [31:0]           out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  host_req_q, host_req_d;
    logic                  start_q, start_d;
    logic                  end_q, end_d;
    logic                  r22_q, r22_d;

    logic                  active;
    logic                  is_empty;
    logic                  is_full;
    logic                  do_pop;
    logic                  push_req;
    logic                  push_ok;
    logic                  drop;
    logic                  underrun;
    logic [LW:0]           prefetch_sum;

    // All event decisions use the occupancy seen at the start of the cycle.
    always_comb begin
        active       = (state_q != ST_IDLE);
        is_empty     = (level_q == '0);
        is_full      = (level_q == LVL_FULL);
        do_pop       = bus.req_tick && active && !is_empty;
        push_req     = bus.sample_valid && active;
        push_ok      = push_req && (!is_full || do_pop);
        drop         = push_req && !push_ok;
        underrun     = bus.req_tick && (state_q == ST_RUN) && bus.req_mode && is_empty;
        prefetch_sum = {1'b0, level_q} - {{LW{1'b0}}, do_pop} + {1'b0, outst_q};
    end

    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        end_d   = 1'b0;
        r22_d   = r22_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_start && !bus.cmd_end) begin
                    state_d = ST_RUN;
                    start_d = 1'b1;
                    r22_d   = bus.cmd_22k;
                end
            end
            ST_RUN: begin
                if (bus.cmd_end) begin
                    state_d = ST_DRAIN;
                end else if (bus.cmd_start) begin
                    start_d = 1'b1;
                    r22_d   = bus.cmd_22k;
                end
            end
            ST_DRAIN: begin
                // A restart beats the stop condition; a stop needs both the
                // buffer and the in-flight host requests to be exhausted.
                if (bus.cmd_start && !bus.cmd_end) begin
                    state_d = ST_RUN;
                    start_d = 1'b1;
                    r22_d   = bus.cmd_22k;
                end else if (is_empty && (outst_q == '0)) begin
                    state_d = ST_IDLE;
                    end_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        level_d     = level_q;
        out_valid_d = do_pop;
        out_data_d  = out_data_q;
        if (do_pop) begin
            out_data_d = mem_q[rd_ptr_q];
            rd_ptr_d   = rd_ptr_q + PTR_ONE;
        end
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        case ({push_ok, do_pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase

        host_req_d = bus.req_tick && (state_q == ST_RUN) && bus.req_mode &&
                     (prefetch_sum < SUM_CAP);

        // Every sample arriving while active answers one earlier request,
        // whether it was stored or dropped.
        outst_d = outst_q;
        if (host_req_d && !push_req) begin
            outst_d = outst_q + LVL_ONE;
        end else if (!host_req_d && push_req && (outst_q != '0)) begin
            outst_d = outst_q - LVL_ONE;
        end
        if ((state_q != ST_IDLE) && (state_d == ST_IDLE)) begin
            outst_d = '0;
        end

        ucnt_d = bus.status_clr ? '0 : ucnt_q;
        if (underrun && (ucnt_d != '1)) begin
            ucnt_d = ucnt_d + UCNT_ONE;
        end
        ovf_d = (bus.status_clr ? 1'b0 : ovf_q) | drop;
    end

    always_ff @(posedge in_clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= bus.sample_data;
        end
    end

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            level_q     <= '0;
            outst_q     <= '0;
            ucnt_q      <= '0;
            ovf_q       <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            host_req_q  <= 1'b0;
            start_q     <= 1'b0;
            end_q       <= 1'b0;
            r22_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            level_q     <= level_d;
            outst_q     <= outst_d;
            ucnt_q      <= ucnt_d;
            ovf_q       <= ovf_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            host_req_q  <= host_req_d;
            start_q     <= start_d;
            end_q       <= end_d;
            r22_q       <= r22_d;
        end
    end

    assign bus.out_valid       = out_valid_q;
    assign bus.out_data        = out_data_q;
    assign bus.audio_start_out = start_q;
    assign bus.audio_end_out   = end_q;
    assign bus.audio_22k_out   = r22_q;
    assign bus.host_req        = host_req_q;
    assign bus.fifo_level      = level_q;
    assign bus.underrun_count  = ucnt_q;
    assign bus.overflow        = ovf_q;
    assign bus.dbg_state       = state_q;
endmodule

// File: tb/tb_audio_out_fifo.sv
// Bench for audio_out_fifo: directed scenarios plus random traffic, all
// checked each cycle against a queue-based behavioural model.
module tb_audio_out_fifo;
    localparam int DL    = 2;
    localparam int UW    = 4;
    localparam int DEPTH = 1 << DL;
    localparam int UMAX  = (1 << UW) - 1;

    logic clk;
    logic rst_n;

    audio_out_fifo_if #(.DEPTH_LOG2(DL), .UCNT_W(UW)) bus ();

    audio_out_fifo #(.DEPTH_LOG2(DL), .UCNT_W(UW)) dut (
        .in_clk (clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] exp_q[$];
    int          m_state;
    int          m_outst;
    int          m_ucnt;
    bit          m_ovf;
    bit          m_r22;
    bit          e_valid, e_req, e_start, e_end;
    logic [31:0] e_data;

    int checks;
    int errors;
    int n_req, n_start, n_end, n_valid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_state = 0; m_outst = 0; m_ucnt = 0; m_ovf = 0; m_r22 = 0;
        e_valid = 0; e_req = 0; e_start = 0; e_end = 0; e_data = '0;
    endtask

    task automatic model_start();
        m_state = 1;
        e_start = 1;
        m_r22   = bus.cmd_22k;
    endtask

    // One clock of the block described at the level of a sample queue.
    task automatic model_step();
        int lvl, outst_pre;
        bit busy, do_pop, under, do_req, dec, ovf_ev;
        lvl       = exp_q.size();
        outst_pre = m_outst;
        busy      = (m_state != 0);
        do_pop    = bus.req_tick && busy && (lvl > 0);
        under     = bus.req_tick && (m_state == 1) && bus.req_mode && (lvl == 0);
        do_req    = bus.req_tick && (m_state == 1) && bus.req_mode &&
                    ((lvl - int'(do_pop) + outst_pre) < DEPTH);
        e_valid = do_pop; e_req = do_req; e_start = 0; e_end = 0;
        if (do_pop) e_data = exp_q.pop_front();
        dec    = bus.sample_valid && busy;
        ovf_ev = 0;
        if (dec) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(bus.sample_data);
            else ovf_ev = 1;
        end
        if (do_req && !dec) m_outst++;
        else if (dec && !do_req && m_outst > 0) m_outst--;
        if (bus.status_clr) begin
            m_ucnt = 0;
            m_ovf  = 0;
        end
        if (under && m_ucnt < UMAX) m_ucnt++;
        if (ovf_ev) m_ovf = 1;
        case (m_state)
            0: if (bus.cmd_start && !bus.cmd_end) model_start();
            1: begin
                if (bus.cmd_end) m_state = 2;
                else if (bus.cmd_start) model_start();
            end
            default: begin
                if (bus.cmd_start && !bus.cmd_end) model_start();
                else if (lvl == 0 && outst_pre == 0) begin
                    m_state = 0;
                    e_end   = 1;
                    m_outst = 0;
                end
            end
        endcase
    endtask

    task automatic compare_all();
        check("out_valid", 32'(bus.out_valid), 32'(e_valid));
        check("out_data", bus.out_data, e_data);
        check("host_req", 32'(bus.host_req), 32'(e_req));
        check("audio_start", 32'(bus.audio_start_out), 32'(e_start));
        check("audio_end", 32'(bus.audio_end_out), 32'(e_end));
        check("audio_22k", 32'(bus.audio_22k_out), 32'(m_r22));
        check("fifo_level", 32'(bus.fifo_level), 32'(exp_q.size()));
        check("underrun_count", 32'(bus.underrun_count), 32'(m_ucnt));
        check("overflow", 32'(bus.overflow), 32'(m_ovf));
        check("state", 32'(bus.dbg_state), 32'(m_state));
        if (bus.host_req === 1'b1) n_req++;
        if (bus.audio_start_out === 1'b1) n_start++;
        if (bus.audio_end_out === 1'b1) n_end++;
        if (bus.out_valid === 1'b1) n_valid++;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input bit st, input bit en, input bit k22, input bit sv,
                         input logic [31:0] sd, input bit tk, input bit clr);
        bus.cmd_start    = st;
        bus.cmd_end      = en;
        bus.cmd_22k      = k22;
        bus.sample_valid = sv;
        bus.sample_data  = sd;
        bus.req_tick     = tk;
        bus.status_clr   = clr;
        cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 32'h0, 0, 0);
    endtask

    task automatic push(input logic [31:0] d);
        drive(0, 0, 0, 1, d, 0, 0);
    endtask

    task automatic tick();
        drive(0, 0, 0, 0, 32'h0, 1, 0);
    endtask

    task automatic zero_inputs();
        bus.cmd_start = 0; bus.cmd_end = 0; bus.cmd_22k = 0; bus.sample_valid = 0;
        bus.sample_data = '0; bus.req_tick = 0; bus.status_clr = 0; bus.req_mode = 0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int base;
        checks = 0; errors = 0;
        n_req = 0; n_start = 0; n_end = 0; n_valid = 0;
        zero_inputs();
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;

        // Sample in IDLE is ignored.
        push(32'hDEADBEEF);
        check("idle_push_level", 32'(bus.fifo_level), 32'd0);
        check("idle_push_ovf", 32'(bus.overflow), 32'd0);

        // Start at 22 kHz, four ticks with nothing buffered.
        bus.req_mode = 1;
        drive(1, 0, 1, 0, 32'h0, 0, 0);
        base = n_req;
        for (int i = 0; i < 4; i++) tick();
        idle(1);
        check("s2_22k", 32'(bus.audio_22k_out), 32'd1);
        check("s2_host_req_cnt", 32'(n_req - base), 32'd4);
        check("s2_underruns", 32'(bus.underrun_count), 32'd4);
        for (int i = 0; i < 4; i++) push(32'h1000 + 32'(i));
        bus.req_mode = 0;
        for (int i = 0; i < 4; i++) tick();
        idle(1);

        // Two samples out in order.
        push(32'hAAAA5555);
        push(32'h12345678);
        check("s3_level2", 32'(bus.fifo_level), 32'd2);
        tick();
        check("s3_first", bus.out_data, 32'hAAAA5555);
        check("s3_level1", 32'(bus.fifo_level), 32'd1);
        tick();
        check("s3_second", bus.out_data, 32'h12345678);
        check("s3_level0", 32'(bus.fifo_level), 32'd0);

        // Overfill, then push while full alongside a pop.
        for (int i = 0; i < 5; i++) push(32'h5000 + 32'(i));
        check("s4_level_full", 32'(bus.fifo_level), 32'd4);
        check("s4_overflow", 32'(bus.overflow), 32'd1);
        drive(0, 0, 0, 1, 32'h5555AAAA, 1, 0);
        check("s4_level_keep", 32'(bus.fifo_level), 32'd4);
        check("s4_pop_head", bus.out_data, 32'h5000);
        for (int i = 0; i < 4; i++) tick();
        check("s4_last", bus.out_data, 32'h5555AAAA);
        drive(0, 0, 0, 0, 32'h0, 0, 1);

        // Drain with two buffered and one outstanding.
        bus.req_mode = 1;
        for (int i = 0; i < 3; i++) tick();
        push(32'h6000);
        push(32'h6001);
        base = n_req;
        drive(0, 1, 0, 0, 32'h0, 0, 0);
        tick();
        tick();
        idle(2);
        check("s5_no_end_yet", 32'(n_end), 32'd0);
        push(32'h6002);
        tick();
        check("s5_third", bus.out_data, 32'h6002);
        idle(1);
        check("s5_end_pulse", 32'(bus.audio_end_out), 32'd1);
        check("s5_idle", 32'(bus.dbg_state), 32'd0);
        check("s5_no_req", 32'(n_req - base), 32'd0);

        // start+end together in RUN, then clear coincident with underrun.
        drive(1, 0, 0, 0, 32'h0, 0, 0);
        base = n_start;
        drive(1, 1, 0, 0, 32'h0, 0, 0);
        check("s6_drain", 32'(bus.dbg_state), 32'd2);
        check("s6_no_start", 32'(n_start - base), 32'd0);
        idle(2);
        drive(1, 0, 0, 0, 32'h0, 0, 0);
        drive(0, 0, 0, 0, 32'h0, 1, 1);
        check("s6_clr_vs_underrun", 32'(bus.underrun_count), 32'd1);

        // Random traffic with one asynchronous reset in the middle.
        for (int i = 0; i < 3000; i++) begin
            bit sv;
            if (i == 1500) begin
                rst_n = 1'b0;
                #2;
                model_reset();
                compare_all();
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
            bus.req_mode = ($urandom_range(0, 9) != 0);
            sv = (m_outst > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 19) == 0);
            drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 49) == 0),
                  1'($urandom_range(0, 1)), sv, $urandom(),
                  ($urandom_range(0, 9) < 3), ($urandom_range(0, 99) == 0));
        end
        idle(2);
        check("activity_seen", 32'(n_valid > 0 && n_req > 0 && n_end > 0), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/audio_out_fifo.md
# audio_out_fifo

Sample buffer and request scheduler between the NeXT sound-out link decoder and the I2S sender. It holds up to 2^DEPTH_LOG2 32-bit stereo samples received from the NeXT hardware. It hands exactly one sample to the I2S sender for each request tick from that sender, and it issues prefetch requests to the NeXT side so the buffer stays ahead of playback. It also owns the start/drain/stop sequencing and the underrun/overflow statistics, all in the in_clk domain.

## Interface
- DEPTH_LOG2, default 2: buffer depth is 2^DEPTH_LOG2 entries (4).
- UCNT_W, default 16: underrun counter width.

- in_clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_start  in  1  one-cycle pulse: NeXT sound-out start.
- cmd_end  in  1  one-cycle pulse: NeXT sound-out end.
- cmd_22k  in  1  rate flag sampled with cmd_start: 1 = 22 kHz, 0 = 44 kHz.
- sample_valid  in  1  one-cycle pulse: sample_data holds one received sample.
- sample_data  in  32  sample, L in [31:16], R in [15:0].
- req_mode  in  1  sender is in request mode (audio_req_mode_out).
- req_tick  in  1  one-cycle pulse: sender wants the next sample.
- status_clr  in  1  clears underrun_count and overflow.
- out_valid  out  1  one-cycle pulse to sender in_valid.
- out_data  out  32  to sender in_data; holds its value between pulses.
- audio_start_out  out  1  one-cycle pulse to sender audio_start_in.
- audio_end_out  out  1  one-cycle pulse to sender audio_end_in.
- audio_22k_out  out  1  latched rate flag to sender audio_22kz_in.
- host_req  out  1  one-cycle pulse: request one sample from NeXT.
- fifo_level  out  DEPTH_LOG2+1  current occupancy.
- underrun_count  out  UCNT_W  saturating underrun count.
- overflow  out  1  sticky: a sample was dropped because the buffer was full.

## Operation
- States: IDLE, RUN, DRAIN. Reset state is IDLE.
- IDLE:
  - cmd_start moves to RUN, pulses audio_start_out, and latches cmd_22k into audio_22k_out.
  - sample_valid is ignored; data is dropped and overflow is not set.
- RUN:
  - cmd_end moves to DRAIN.
  - cmd_start re-pulses audio_start_out and re-latches the rate flag, with no state change.
- DRAIN:
  - No host_req is issued.
  - cmd_start returns to RUN with an audio_start_out pulse.
  - When fifo_level==0 and outstanding==0, the block pulses audio_end_out and moves to IDLE.
- If cmd_start and cmd_end occur in the same cycle, cmd_end wins.
- FIFO: circular, with DEPTH_LOG2-bit read and write pointers that wrap.
  - sample_valid in RUN or DRAIN pushes the sample if not full.
  - If full, the sample is dropped and overflow is set.
  - If full and a pop happens in the same cycle, the push is accepted.
- Pop happens on req_tick in RUN or DRAIN, using the pre-cycle state:
  - Not empty: out_data<=head, out_valid pulses, and the read pointer advances.
  - Empty in RUN with req_mode=1: underrun_count increments, saturating at all-ones.
  - Empty in that cycle with a simultaneous push: the push is stored, and the pop still counts as an underrun.
- Outstanding counter (DEPTH_LOG2+1 bits):
  - Increments on host_req.
  - Decrements on accepted or dropped sample_valid, saturating at 0.
  - Simultaneous increment and decrement leaves it unchanged.
  - Cleared on entering IDLE.
- Prefetch: on req_tick in RUN with req_mode=1 and fifo_level+outstanding (after this cycle's pop) < 2^DEPTH_LOG2, host_req pulses. At most one host_req per req_tick.
- status_clr: clears underrun_count and overflow. If an increment or set event occurs in the same cycle, the event wins.
- Reset mid-operation: all state goes to IDLE, FIFO empty, counters 0, every output 0. out_data resets to 0.

## Timing
- out_valid, host_req, audio_start_out and audio_end_out are registered. Each appears exactly 1 cycle after its causing input (req_tick, cmd_start) or condition.
- fifo_level updates 1 cycle after the push or pop.
- audio_end_out asserts 1 cycle after the DRAIN-empty condition is first seen. IDLE is entered in the same cycle.
- Back-to-back req_tick on consecutive cycles is legal. Each tick pops and requests independently.
- Push-to-pop minimum latency: a sample pushed at cycle N can be popped by a req_tick at N+1 and appears on out_valid at N+2.

## Test plan
- Reset → all outputs 0, fifo_level=0, state IDLE. A sample_valid in IDLE leaves fifo_level at 0 and overflow at 0.
- cmd_start with cmd_22k=1, req_mode=1, 4 req_ticks with no samples → audio_22k_out=1, 4 host_req pulses 1 cycle after each tick, underrun_count=4.
- In RUN, push 0xAAAA5555 then 0x12345678, then 2 req_ticks → out_valid twice with those values in order. fifo_level goes 2→1→0.
- Push 5 samples into 4-deep buffer → fifo_level=4, overflow=1. A 5th push simultaneous with a req_tick → accepted, level stays 4.
- cmd_end with 2 samples buffered and 1 outstanding → no host_req. audio_end_out pulses only after 2 pops and 1 sample arrival/pop. State returns to IDLE.
- cmd_start and cmd_end in the same cycle while in RUN → DRAIN, no audio_start_out. status_clr concurrent with underrun → underrun_count=1.
